// File: rtl/axi4_tm_pkg.sv
// Shared types and helpers for the AXI4 SRAM test master.
// Holds the FSM state encoding, AXI burst/response codes and the data pattern.
package axi4_tm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW,
    S_WR_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_FIN
  } tm_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // One 64-bit pattern word for global beat index i: inverted index in the upper half.
  function automatic logic [63:0] pattern_f(input logic [31:0] i);
    return {~i, i};
  endfunction

endpackage

// File: rtl/axi4_sram_test_master.sv
// AXI4 traffic generator: writes a deterministic pattern over NUM_BURSTS INCR bursts,
// reads everything back, compares, and reports DONE/PASS plus a saturating error count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START; DONE/PASS hold the last pass result
// S_WR_AW | write address presented, waiting for AWREADY
// S_WR_W  | streaming BURST_LEN write beats
// S_WR_B  | waiting for the write response of the current burst
// S_RD_AR | read address presented, waiting for ARREADY
// S_RD_R  | accepting and checking read beats of the current burst
// S_FIN   | publishing DONE/PASS, then back to idle
module axi4_sram_test_master
  import axi4_tm_pkg::*;
#(
  parameter int              AXI4_AWIDTH  = 32,
  parameter int              AXI4_DWIDTH  = 64,
  parameter int              AXI4_IDWIDTH = 4,
  parameter int              AXI_ID       = 0,
  parameter longint unsigned BASE_ADDR    = 0,
  parameter int              BURST_LEN    = 16,
  parameter int              NUM_BURSTS   = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      PASS,
  output logic [15:0]               ERR_COUNT,
  output logic [AXI4_IDWIDTH-1:0]   AWID,
  output logic [AXI4_AWIDTH-1:0]    AWADDR,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [AXI4_DWIDTH-1:0]    WDATA,
  output logic [AXI4_DWIDTH/8-1:0]  WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [AXI4_IDWIDTH-1:0]   BID,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [AXI4_IDWIDTH-1:0]   ARID,
  output logic [AXI4_AWIDTH-1:0]    ARADDR,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [AXI4_DWIDTH-1:0]    RDATA,
  input  logic [AXI4_IDWIDTH-1:0]   RID,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int BEAT_BYTES  = AXI4_DWIDTH / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int BCW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int REP         = (AXI4_DWIDTH + 63) / 64;

  localparam logic [BCW-1:0] LAST_BURST = BCW'(NUM_BURSTS - 1);
  localparam logic [7:0]     LAST_BEAT  = 8'(BURST_LEN - 1);

  tm_state_e        state;
  logic [BCW-1:0]   burst_cnt;
  logic [7:0]       beat_cnt;
  logic [31:0]      beat_idx;
  logic [31:0]      burst_base;
  logic [REP*64-1:0] pat_wide;
  logic [AXI4_DWIDTH-1:0] pat;
  logic             last_beat;
  logic             r_hs;
  logic             b_hs;
  logic             rresp_bad;
  logic             rdata_bad;
  logic             rlast_bad;
  logic [1:0]       err_inc;
  logic [16:0]      err_sum;
  logic [15:0]      err_next;
  logic             unused_ids;

  assign unused_ids = ^{BID, RID};

  // Burst address and payload are pure functions of registered counters,
  // so they stay put for as long as the matching VALID is held.
  assign AWID    = AXI4_IDWIDTH'(AXI_ID);
  assign ARID    = AXI4_IDWIDTH'(AXI_ID);
  assign AWADDR  = AXI4_AWIDTH'(BASE_ADDR) + AXI4_AWIDTH'(burst_cnt) * AXI4_AWIDTH'(BURST_BYTES);
  assign ARADDR  = AWADDR;
  assign AWLEN   = LAST_BEAT;
  assign ARLEN   = LAST_BEAT;
  assign AWSIZE  = 3'($clog2(BEAT_BYTES));
  assign ARSIZE  = AWSIZE;
  assign AWBURST = AXI_BURST_INCR;
  assign ARBURST = AXI_BURST_INCR;
  assign WSTRB   = '1;

  assign pat_wide   = {REP{pattern_f(beat_idx)}};
  assign pat        = pat_wide[AXI4_DWIDTH-1:0];
  assign WDATA      = pat;
  assign burst_base = 32'(burst_cnt) * 32'(BURST_LEN);
  assign last_beat  = (beat_cnt == LAST_BEAT);

  assign b_hs      = (state == S_WR_B) && BVALID && BREADY;
  assign r_hs      = (state == S_RD_R) && RVALID && RREADY;
  assign rresp_bad = (RRESP != AXI_RESP_OKAY);
  assign rdata_bad = (RDATA != pat);
  assign rlast_bad = (RLAST != last_beat);

  // Each failing check on a beat counts separately; the total saturates.
  always_comb begin
    err_inc = 2'd0;
    if (b_hs && (BRESP != AXI_RESP_OKAY)) begin
      err_inc = 2'd1;
    end else if (r_hs) begin
      err_inc = {1'b0, rresp_bad} + {1'b0, rdata_bad} + {1'b0, rlast_bad};
    end
    err_sum  = {1'b0, ERR_COUNT} + {15'd0, err_inc};
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_COUNT <= 16'd0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      WLAST     <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      burst_cnt <= '0;
      beat_cnt  <= '0;
      beat_idx  <= '0;
    end else begin
      ERR_COUNT <= err_next;
      case (state)
        S_IDLE: begin
          if (START) begin
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_COUNT <= 16'd0;
            burst_cnt <= '0;
            beat_idx  <= '0;
            AWVALID   <= 1'b1;
            state     <= S_WR_AW;
          end
        end
        S_WR_AW: begin
          if (AWVALID && AWREADY) begin
            AWVALID  <= 1'b0;
            WVALID   <= 1'b1;
            WLAST    <= (LAST_BEAT == 8'd0);
            beat_cnt <= '0;
            state    <= S_WR_W;
          end
        end
        S_WR_W: begin
          if (WVALID && WREADY) begin
            beat_idx <= beat_idx + 32'd1;
            if (WLAST) begin
              WVALID <= 1'b0;
              WLAST  <= 1'b0;
              BREADY <= 1'b1;
              state  <= S_WR_B;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              WLAST    <= ((beat_cnt + 8'd1) == LAST_BEAT);
            end
          end
        end
        S_WR_B: begin
          if (b_hs) begin
            BREADY <= 1'b0;
            if (burst_cnt == LAST_BURST) begin
              burst_cnt <= '0;
              ARVALID   <= 1'b1;
              state     <= S_RD_AR;
            end else begin
              burst_cnt <= burst_cnt + BCW'(1);
              AWVALID   <= 1'b1;
              state     <= S_WR_AW;
            end
          end
        end
        S_RD_AR: begin
          if (ARVALID && ARREADY) begin
            ARVALID  <= 1'b0;
            RREADY   <= 1'b1;
            beat_cnt <= '0;
            beat_idx <= burst_base;
            state    <= S_RD_R;
          end
        end
        S_RD_R: begin
          // A burst ends on the slave's RLAST or after BURST_LEN beats, whichever is first.
          if (r_hs) begin
            if (RLAST || last_beat) begin
              RREADY <= 1'b0;
              if (burst_cnt == LAST_BURST) begin
                state <= S_FIN;
              end else begin
                burst_cnt <= burst_cnt + BCW'(1);
                ARVALID   <= 1'b1;
                state     <= S_RD_AR;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              beat_idx <= beat_idx + 32'd1;
            end
          end
        end
        S_FIN: begin
          DONE  <= 1'b1;
          PASS  <= (ERR_COUNT == 16'd0);
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_sram_test_master.sv
// Bench for axi4_sram_test_master: behavioural 512x64 AXI4 SRAM slave with stalls and
// fault injection, a table of pass scenarios, random scenarios, and reset/restart sequences.
module tb_axi4_sram_test_master;

  localparam int DW          = 64;
  localparam int AW          = 32;
  localparam int IDW         = 4;
  localparam int BL          = 16;
  localparam int NB          = 32;
  localparam int WORDS       = 512;
  localparam int BURST_BYTES = BL * DW / 8;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic START = 1'b0;
  logic BUSY, DONE, PASS;
  logic [15:0] ERR_COUNT;
  logic [IDW-1:0] AWID, ARID;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST;
  logic AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
  logic [DW-1:0] WDATA;
  logic [DW/8-1:0] WSTRB;
  logic AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0;
  logic [1:0] BRESP = 2'b00, RRESP = 2'b00;
  logic [IDW-1:0] BID = '0, RID = '0;
  logic [DW-1:0] RDATA = '0;

  always #5 ACLK = ~ACLK;

  axi4_sram_test_master #(
    .AXI4_AWIDTH(AW), .AXI4_DWIDTH(DW), .AXI4_IDWIDTH(IDW), .AXI_ID(0),
    .BASE_ADDR(0), .BURST_LEN(BL), .NUM_BURSTS(NB)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .START(START),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    int stall_pct;
    int bresp_burst;
    int rresp_beat;
    int flip_word;
    int early_burst;
    int miss_burst;
    int restarts;
    int exp_err;
    int exp_pass;
  } vec_t;

  // slave configuration (written by the test sequence only)
  int stall_pct = 0, bresp_burst = -1, rresp_beat = -1, flip_word = -1;
  int early_burst = -1, miss_burst = -1, aw_base = 0, ar_base = 0;

  // slave state and statistics (written by the slave process only)
  logic [DW-1:0] mem [0:WORDS-1];
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, proto_err = 0;
  int w_state = 0, r_state = 0, w_burst = 0, w_beat = 0, r_burst = 0, r_beat = 0;
  bit b_hs = 0, r_hs = 0, r_end = 0, prev_ok = 0;
  logic prev_awv, prev_wv, prev_arv, prev_wlast;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [DW-1:0] prev_wdata;

  int n_checks = 0, n_fail = 0;

  function automatic bit stall();
    return (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
  endfunction

  function automatic logic [63:0] ref_word(input int i);
    logic [31:0] ii;
    ii = i;
    return {~ii, ii};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural slave: decisions at negedge, handshakes complete at the following posedge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; ARREADY = 1'b0;
      RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = '0;
      w_state = 0; r_state = 0; b_hs = 0; r_hs = 0; r_end = 0; prev_ok = 0;
    end else begin
      if (prev_ok) begin
        if (prev_awv && !AWREADY && (!AWVALID || AWADDR != prev_awaddr)) proto_err++;
        if (prev_wv && !WREADY && (!WVALID || WDATA != prev_wdata || WLAST != prev_wlast)) proto_err++;
        if (prev_arv && !ARREADY && (!ARVALID || ARADDR != prev_araddr)) proto_err++;
      end
      if (b_hs) begin
        BVALID = 1'b0; BRESP = 2'b00; b_hs = 0; b_cnt++; w_state = 0;
      end else if (w_state == 2 && !BVALID) begin
        BVALID = 1'b1;
        BRESP  = (w_burst == bresp_burst) ? 2'b10 : 2'b00;
      end
      if (r_hs) begin
        r_hs = 0; r_cnt++; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        if (r_end) r_state = 0;
        else r_beat++;
      end
      AWREADY = (w_state == 0) && AWVALID && !stall();
      if (AWREADY) begin
        if (AWADDR != AW'((aw_cnt - aw_base) * BURST_BYTES) || AWLEN != 8'(BL - 1) ||
            AWSIZE != 3'd3 || AWBURST != 2'b01 || AWID != '0) proto_err++;
        w_burst = int'(AWADDR) / BURST_BYTES; w_beat = 0; w_state = 1; aw_cnt++;
      end
      WREADY = (w_state == 1) && !stall();
      if (WREADY && WVALID) begin
        mem[(w_burst * BL + w_beat) % WORDS] = WDATA;
        if (WSTRB != '1 || WLAST != (w_beat == BL - 1)) proto_err++;
        w_cnt++; w_beat++;
        if (WLAST || w_beat == BL) w_state = 2;
      end
      ARREADY = (r_state == 0) && ARVALID && !stall();
      if (ARREADY) begin
        if (ARADDR != AW'((ar_cnt - ar_base) * BURST_BYTES) || ARLEN != 8'(BL - 1) ||
            ARSIZE != 3'd3 || ARBURST != 2'b01 || ARID != '0) proto_err++;
        if (ar_cnt == ar_base && flip_word >= 0) mem[flip_word] = mem[flip_word] ^ 64'd1;
        r_burst = int'(ARADDR) / BURST_BYTES; r_beat = 0; r_state = 1; ar_cnt++;
      end
      if (r_state == 1 && !RVALID && !stall()) begin
        RVALID = 1'b1;
        RDATA  = mem[(r_burst * BL + r_beat) % WORDS];
        RRESP  = (r_burst * BL + r_beat == rresp_beat) ? 2'b10 : 2'b00;
        r_end  = (r_burst == early_burst && r_beat == 5) || (r_beat == BL - 1);
        RLAST  = (r_burst == miss_burst) ? 1'b0 : r_end;
      end
      if (BVALID && BREADY) b_hs = 1;
      if (RVALID && RREADY) r_hs = 1;
      prev_ok = 1;
      prev_awv = AWVALID; prev_awaddr = AWADDR;
      prev_wv = WVALID; prev_wdata = WDATA; prev_wlast = WLAST;
      prev_arv = ARVALID; prev_araddr = ARADDR;
    end
  end

  task automatic run_pass(input vec_t v, input string tag);
    int aw0, w0, b0, ar0, r0, pe0, cyc, bad, exp_r;
    logic [63:0] want;
    stall_pct = v.stall_pct; bresp_burst = v.bresp_burst; rresp_beat = v.rresp_beat;
    flip_word = v.flip_word; early_burst = v.early_burst; miss_burst = v.miss_burst;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt; pe0 = proto_err;
    aw_base = aw_cnt; ar_base = ar_cnt;
    @(negedge ACLK); START = 1'b1;
    @(negedge ACLK); START = 1'b0;
    #1;
    check({tag, "_busy_rise"}, BUSY, 1);
    check({tag, "_done_clr"}, DONE, 0);
    cyc = 0;
    while (!DONE && cyc < 20000) begin
      @(negedge ACLK); #1;
      cyc++;
      START = (v.restarts != 0) && (cyc == 100 || cyc == 600);
    end
    START = 1'b0;
    check({tag, "_done"}, DONE, 1);
    check({tag, "_pass"}, PASS, v.exp_pass);
    check({tag, "_err_count"}, ERR_COUNT, v.exp_err);
    check({tag, "_busy_fall"}, BUSY, 0);
    check({tag, "_aw_hs"}, aw_cnt - aw0, NB);
    check({tag, "_w_beats"}, w_cnt - w0, NB * BL);
    check({tag, "_b_hs"}, b_cnt - b0, NB);
    check({tag, "_ar_hs"}, ar_cnt - ar0, NB);
    exp_r = NB * BL - ((v.early_burst >= 0) ? (BL - 6) : 0);
    check({tag, "_r_beats"}, r_cnt - r0, exp_r);
    check({tag, "_protocol"}, proto_err - pe0, 0);
    bad = 0;
    for (int i = 0; i < WORDS; i++) begin
      want = ref_word(i);
      if (i == v.flip_word) want = want ^ 64'd1;
      if (mem[i] !== want) bad++;
    end
    check({tag, "_ram_image"}, bad, 0);
  endtask

  vec_t vecs[$];
  vec_t rv;
  vec_t clean;
  int bb[4];
  int cyc;
  int w0;

  initial begin
    // stall, bresp_burst, rresp_beat, flip_word, early, miss, restarts, exp_err, exp_pass
    vecs.push_back(vec_t'{0,  -1, -1,  -1,  -1, -1, 0, 0, 1});
    vecs.push_back(vec_t'{0,  -1, -1,  100, -1, -1, 0, 1, 0});
    vecs.push_back(vec_t'{30, -1, -1,  -1,  -1, -1, 1, 0, 1});
    vecs.push_back(vec_t'{0,  3,  77,  -1,  -1, -1, 0, 2, 0});
    vecs.push_back(vec_t'{20, -1, -1,  -1,  9,  -1, 0, 1, 0});
    vecs.push_back(vec_t'{20, -1, -1,  -1,  -1, 20, 0, 1, 0});
    vecs.push_back(vec_t'{25, 31, 511, 3,   -1, -1, 0, 3, 0});
    for (int k = 0; k < 3; k++) begin
      rv.stall_pct = $urandom_range(40);
      bb[0] = $urandom_range(NB - 1);
      for (int j = 1; j < 4; j++) bb[j] = (bb[0] + 1 + 7 * j) % NB;
      rv.exp_err = 0;
      rv.bresp_burst = -1; rv.rresp_beat = -1; rv.flip_word = -1;
      rv.early_burst = -1; rv.miss_burst = -1; rv.restarts = 0;
      if ($urandom_range(1) == 1) begin rv.bresp_burst = $urandom_range(NB - 1); rv.exp_err++; end
      if ($urandom_range(1) == 1) begin rv.rresp_beat = bb[0] * BL + int'($urandom_range(BL - 1)); rv.exp_err++; end
      if ($urandom_range(1) == 1) begin rv.flip_word = bb[1] * BL + int'($urandom_range(BL - 1)); rv.exp_err++; end
      if ($urandom_range(1) == 1) begin rv.early_burst = bb[2]; rv.exp_err++; end
      if ($urandom_range(1) == 1) begin rv.miss_burst = bb[3]; rv.exp_err++; end
      rv.exp_pass = (rv.exp_err == 0) ? 1 : 0;
      vecs.push_back(rv);
    end
    clean = vecs[0];

    repeat (4) @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_pass", PASS, 0);
    check("reset_err_count", ERR_COUNT, 0);
    check("reset_handshake_outs", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      run_pass(vecs[n], $sformatf("vec%0d", n));
      if (n == 0) check("ram_word5", mem[5], 64'hFFFFFFFA_00000005);
    end

    // reset in the middle of the first write burst, then a full clean pass
    stall_pct = 0; bresp_burst = -1; rresp_beat = -1; flip_word = -1;
    early_burst = -1; miss_burst = -1;
    aw_base = aw_cnt; ar_base = ar_cnt;
    w0 = w_cnt;
    @(negedge ACLK); START = 1'b1;
    @(negedge ACLK); START = 1'b0;
    cyc = 0;
    while ((w_cnt - w0) < 7 && cyc < 2000) begin
      @(negedge ACLK); #2;
      cyc++;
    end
    check("midrst_reached_beat7", ((w_cnt - w0) >= 7) ? 1 : 0, 1);
    ARESET = 1'b1;
    #1;
    check("midrst_handshake_outs", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_done", DONE, 0);
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    run_pass(clean, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
